// File: rtl/geogenius_pkg.sv
// Purpose : shared types and constants for the geogenius memory game.
// Latency : n/a (package only).
// Backpressure: n/a.
package geogenius_pkg;

    // FSM state; the encodings are the values shown on db_estado.
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        SORTEIA     = 4'h2,
        MOSTRA      = 4'h3,
        APAGA       = 4'h4,
        ESPERA      = 4'h5,
        COMPARA     = 4'h6,
        PROX_JOGADA = 4'h7,
        PROX_RODADA = 4'h8,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hE,
        FIM_TIMEOUT = 4'hF
    } estado_t;

    // Feedback taps 16,14,13,11 (bit positions 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Round/jogada indices and memory entries are 5 bits (up to 32 rounds).
    localparam int IDX_W     = 5;
    localparam int MEM_DEPTH = 32;

endpackage

// File: rtl/geogenius_lfsr.sv
// Purpose : 16-bit free-running Fibonacci LFSR, one step per clock.
// Latency : new value every cycle; seeded by reset.
// Backpressure: none, never stalls.
// Ports   : clk_i, rst_ni (async active-low), lfsr_o (current state).
module geogenius_lfsr
    import geogenius_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Maximal-length polynomial: a nonzero seed never reaches zero.
    assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/geogenius_n.sv
// Purpose : Simon-style memory game: show a growing random LED sequence, check the player's echo.
// Latency : each element lit T_LED then dark T_LED cycles; a press is judged two cycles after it appears.
// Backpressure: none; a button held into ESPERA is ignored until all buttons are released.
// Ports   : clock/reset, jogar (start), dificuldade, botoes -> leds, pronto/acertou/errou/timeout,
//           score (completed rounds), tempo_de_jogo (ticks spent waiting), db_estado (state code).
module geogenius_n
    import geogenius_pkg::*;
#(
    parameter int          NUM_BOTOES        = 8,
    parameter int          MAX_RODADAS       = 16,
    parameter int          T_LED             = 1000,
    parameter int          T_TIMEOUT_FACIL   = 5000,
    parameter int          T_TIMEOUT_DIFICIL = 2500,
    parameter int          T_TICK            = 1000,
    parameter logic [15:0] SEMENTE           = 16'hACE1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               jogar,
    input  logic                               dificuldade,
    input  logic [NUM_BOTOES-1:0]              botoes,
    output logic [NUM_BOTOES-1:0]              leds,
    output logic                               pronto,
    output logic                               acertou,
    output logic                               errou,
    output logic                               timeout,
    output logic [$clog2(MAX_RODADAS+1)-1:0]   score,
    output logic [15:0]                        tempo_de_jogo,
    output logic [3:0]                         db_estado
);

    localparam int SW = $clog2(MAX_RODADAS+1);

    estado_t           state_q;
    logic [IDX_W-1:0]  rod_q;
    logic [IDX_W-1:0]  jog_q;
    logic [SW-1:0]     score_q;
    logic [15:0]       tempo_q;
    logic [31:0]       cnt_q;      // shared by MOSTRA/APAGA timing and the ESPERA timeout
    logic [31:0]       tick_q;
    logic              dif_q;
    logic [NUM_BOTOES-1:0] btn_prev_q;
    logic [NUM_BOTOES-1:0] btn_reg_q;
    logic              pronto_q, acertou_q, errou_q, timeout_q;

    // Full 32-entry array so a 5-bit index always fits; entries past MAX_RODADAS are never written.
    logic [IDX_W-1:0]  mem_q [MEM_DEPTH];

    logic [15:0]       lfsr;
    logic              unused_lfsr;
    logic [IDX_W-1:0]  sorteio;
    logic [NUM_BOTOES-1:0] led_alvo;
    logic              fez_jogada;
    logic [31:0]       tmo_lim;

    geogenius_lfsr #(.SEED(SEMENTE)) u_lfsr (
        .clk_i  (clock),
        .rst_ni (reset),
        .lfsr_o (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:IDX_W];
    assign sorteio     = lfsr[IDX_W-1:0] % IDX_W'(NUM_BOTOES);
    assign led_alvo    = NUM_BOTOES'(1) << mem_q[jog_q];
    // A new press is a rising edge of "any button down", so a held button never repeats.
    assign fez_jogada  = (btn_prev_q == '0) && (botoes != '0);
    assign tmo_lim     = dif_q ? 32'(T_TIMEOUT_DIFICIL - 1) : 32'(T_TIMEOUT_FACIL - 1);

    always_ff @(posedge clock) begin
        if (state_q == SORTEIA) mem_q[rod_q] <= sorteio;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= INICIAL;
            rod_q      <= '0;
            jog_q      <= '0;
            score_q    <= '0;
            tempo_q    <= '0;
            cnt_q      <= '0;
            tick_q     <= '0;
            dif_q      <= 1'b0;
            btn_prev_q <= '0;
            btn_reg_q  <= '0;
            pronto_q   <= 1'b0;
            acertou_q  <= 1'b0;
            errou_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            btn_prev_q <= botoes;
            case (state_q)
                INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                    if (jogar) state_q <= PREPARA;
                end
                PREPARA: begin
                    rod_q     <= '0;
                    jog_q     <= '0;
                    score_q   <= '0;
                    tempo_q   <= '0;
                    tick_q    <= '0;
                    cnt_q     <= '0;
                    dif_q     <= dificuldade;
                    pronto_q  <= 1'b0;
                    acertou_q <= 1'b0;
                    errou_q   <= 1'b0;
                    timeout_q <= 1'b0;
                    state_q   <= SORTEIA;
                end
                SORTEIA: begin
                    jog_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= MOSTRA;
                end
                MOSTRA: begin
                    if (cnt_q == 32'(T_LED - 1)) begin
                        cnt_q   <= '0;
                        state_q <= APAGA;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                APAGA: begin
                    if (cnt_q == 32'(T_LED - 1)) begin
                        cnt_q <= '0;
                        if (jog_q < rod_q) begin
                            jog_q   <= jog_q + 1'b1;
                            state_q <= MOSTRA;
                        end else begin
                            jog_q   <= '0;
                            state_q <= ESPERA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ESPERA: begin
                    // Play time accumulates over every waiting cycle of the game.
                    if (tick_q == 32'(T_TICK - 1)) begin
                        tick_q <= '0;
                        if (tempo_q != 16'hFFFF) tempo_q <= tempo_q + 16'd1;
                    end else begin
                        tick_q <= tick_q + 32'd1;
                    end
                    if (fez_jogada) begin
                        btn_reg_q <= botoes;
                        state_q   <= COMPARA;
                    end else if (cnt_q == tmo_lim) begin
                        pronto_q  <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= FIM_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                COMPARA: begin
                    // Exact match against the one-hot target also rejects multi-button presses.
                    if (btn_reg_q != led_alvo) begin
                        pronto_q <= 1'b1;
                        errou_q  <= 1'b1;
                        state_q  <= FIM_ERRO;
                    end else begin
                        state_q <= PROX_JOGADA;
                    end
                end
                PROX_JOGADA: begin
                    if (jog_q < rod_q) begin
                        if (botoes == '0) begin
                            jog_q   <= jog_q + 1'b1;
                            cnt_q   <= '0;
                            state_q <= ESPERA;
                        end
                    end else begin
                        state_q <= PROX_RODADA;
                    end
                end
                PROX_RODADA: begin
                    score_q <= score_q + SW'(1);
                    if (rod_q == IDX_W'(MAX_RODADAS - 1)) begin
                        pronto_q  <= 1'b1;
                        acertou_q <= 1'b1;
                        state_q   <= FIM_ACERTO;
                    end else begin
                        rod_q   <= rod_q + 1'b1;
                        state_q <= SORTEIA;
                    end
                end
                default: state_q <= INICIAL;
            endcase
        end
    end

    // LEDs decode straight from the state register and memory, dark outside MOSTRA.
    assign leds          = (state_q == MOSTRA) ? led_alvo : '0;
    assign pronto        = pronto_q;
    assign acertou       = acertou_q;
    assign errou         = errou_q;
    assign timeout       = timeout_q;
    assign score         = score_q;
    assign tempo_de_jogo = tempo_q;
    assign db_estado     = state_q;

endmodule

// File: tb/tb_geogenius_n.sv
// Purpose : randomized self-checking bench for geogenius_n with an end-of-game scoreboard.
// Latency : n/a.
// Backpressure: n/a.
module tb_geogenius_n;

    localparam int NB = 4;
    localparam int MR = 3;
    localparam int TL = 4;
    localparam int TF = 20;
    localparam int TD = 10;
    localparam int TT = 2;
    localparam int SW = $clog2(MR+1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          jogar = 1'b0;
    logic          dificuldade = 1'b0;
    logic [NB-1:0] botoes = '0;
    logic [NB-1:0] leds;
    logic          pronto, acertou, errou, timeout;
    logic [SW-1:0] score;
    logic [15:0]   tempo_de_jogo;
    logic [3:0]    db_estado;

    geogenius_n #(
        .NUM_BOTOES(NB), .MAX_RODADAS(MR), .T_LED(TL),
        .T_TIMEOUT_FACIL(TF), .T_TIMEOUT_DIFICIL(TD), .T_TICK(TT), .SEMENTE(16'hACE1)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .dificuldade(dificuldade),
        .botoes(botoes), .leds(leds), .pronto(pronto), .acertou(acertou),
        .errou(errou), .timeout(timeout), .score(score),
        .tempo_de_jogo(tempo_de_jogo), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] res;    // {acertou, errou, timeout}
        int         score;
        int         tempo;
        logic [3:0] st;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int oh_idx(input logic [NB-1:0] v);
        int r = -1;
        for (int k = 0; k < NB; k++) if (v[k]) r = k;
        return r;
    endfunction

    function automatic int tempo_of(input int esp_cycles);
        int t = esp_cycles / TT;
        return (t > 65535) ? 65535 : t;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic recover();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        sb_q.delete();
    endtask

    // Monitor: every rising pronto retires one scoreboard entry.
    exp_t mon_e;
    logic pronto_d = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            if (db_estado == 4'h3) chk("leds_onehot_in_mostra", 32'($onehot(leds)), 1);
            else                   chk("leds_dark", 32'(leds), 0);
            if (pronto && !pronto_d) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_game_end", 32'(db_estado), 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("result_flags", {29'd0, acertou, errou, timeout}, 32'(mon_e.res));
                    chk("final_score", 32'(score), mon_e.score);
                    chk("final_tempo", 32'(tempo_de_jogo), mon_e.tempo);
                    chk("final_state", 32'(db_estado), 32'(mon_e.st));
                end
            end
        end
        pronto_d = pronto;
    end

    task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (db_estado == s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) chk("wait_state_budget", 32'(db_estado), 32'(s));
    endtask

    task automatic wait_end(input int exp_tempo);
        bit ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (pronto) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) begin
            chk("game_end_reached", 0, 1);
            recover();
            return;
        end
        tick(4);
        chk("tempo_held_in_fim", 32'(tempo_de_jogo), exp_tempo);
        chk("pronto_held", 32'(pronto), 1);
    endtask

    // kind: 0 win, 1 wrong single button, 2 two buttons, 3 no press (timeout); tr/tj pick the faulty step.
    task automatic play_game(input int kind, input int tr, input int tj, input bit dif,
                             input bit hold_test, input bit abort);
        int shown[$];
        int prev_seq[$];
        int esp, lit, entry, tmo;
        bit ok, bad;
        logic [NB-1:0] v;
        esp = 0;
        prev_seq = {};
        @(negedge clock);
        dificuldade = dif;
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
        @(negedge clock);
        // The level was latched at PREPARA; flipping it now must not change the timeout.
        dificuldade = ~dif;
        chk("score_cleared_at_start", 32'(score), 0);
        chk("tempo_cleared_at_start", 32'(tempo_de_jogo), 0);
        chk("pronto_cleared_at_start", 32'(pronto), 0);
        for (int r = 0; r < MR; r++) begin
            shown = {};
            lit = 0;
            ok = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if (abort && r == 1 && db_estado == 4'h3) begin
                    #1 reset = 1'b0;
                    #1;
                    chk("async_reset_state", 32'(db_estado), 0);
                    chk("async_reset_leds", 32'(leds), 0);
                    chk("async_reset_score", 32'(score), 0);
                    chk("async_reset_tempo", 32'(tempo_de_jogo), 0);
                    chk("async_reset_flags", {28'd0, pronto, acertou, errou, timeout}, 0);
                    @(negedge clock);
                    reset = 1'b1;
                    return;
                end
                if (hold_test && r == 1 && db_estado == 4'h4 && shown.size() == r + 1)
                    botoes = 4'b0001;
                if (leds != '0) begin
                    if (lit == 0) shown.push_back(oh_idx(leds));
                    lit++;
                end else if (lit != 0) begin
                    chk("led_lit_cycles", lit, TL);
                    lit = 0;
                end
                if (db_estado == 4'h5) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clock);
            end
            if (!ok) begin
                chk("reach_espera", 0, 1);
                recover();
                return;
            end
            chk("seq_length", shown.size(), r + 1);
            for (int j = 0; j < r && j < shown.size(); j++)
                chk("seq_prefix_kept", shown[j], prev_seq[j]);
            prev_seq = shown;
            for (int j = 0; j <= r; j++) begin
                if (j > 0) begin
                    wait_state(4'h5, 50, ok);
                    if (!ok) begin
                        recover();
                        return;
                    end
                end
                entry = cyc;
                if (kind == 3 && r == tr && j == tj) begin
                    tmo = dif ? TD : TF;
                    esp += tmo;
                    sb_q.push_back('{3'b001, r, tempo_of(esp), 4'hF});
                    for (int c = 0; c < 60; c++) begin
                        @(negedge clock);
                        if (timeout) break;
                    end
                    chk("timeout_latency", cyc - entry, tmo);
                    wait_end(tempo_of(esp));
                    return;
                end
                if (hold_test && r == 1 && j == 0) begin
                    tick(3);
                    chk("held_button_no_event", 32'(db_estado), 32'h5);
                    botoes = '0;
                    tick(1);
                end else begin
                    tick($urandom_range(0, 2));
                end
                v = NB'(1) << shown[j];
                bad = 1'b0;
                if (kind == 1 && r == tr && j == tj) begin
                    v = NB'(1) << ((shown[j] + 1 + $urandom_range(0, 2)) % NB);
                    bad = 1'b1;
                end
                if (kind == 2 && r == tr && j == tj) begin
                    v = v | (NB'(1) << ((shown[j] + 1) % NB));
                    bad = 1'b1;
                end
                esp += cyc - entry + 1;
                botoes = v;
                if (bad)
                    sb_q.push_back('{3'b010, r, tempo_of(esp), 4'hE});
                else if (r == MR - 1 && j == r)
                    sb_q.push_back('{3'b100, MR, tempo_of(esp), 4'hA});
                tick(1);
                botoes = '0;
                if (bad || (r == MR - 1 && j == r)) begin
                    wait_end(tempo_of(esp));
                    return;
                end
            end
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        tick(2);
        chk("reset_state", 32'(db_estado), 0);
        chk("reset_leds", 32'(leds), 0);
        chk("reset_flags", {28'd0, pronto, acertou, errou, timeout}, 0);
        chk("reset_score", 32'(score), 0);
        chk("reset_tempo", 32'(tempo_de_jogo), 0);
        reset = 1'b1;
        tick(3);
        chk("idle_without_jogar", 32'(db_estado), 0);

        play_game(0, 0, 0, 1'b0, 1'b0, 1'b0);                       // full win
        play_game(1, 1, $urandom_range(0, 1), 1'b0, 1'b0, 1'b0);   // wrong button in second round
        play_game(2, 0, 0, 1'b1, 1'b0, 1'b0);                       // two buttons at once
        play_game(3, 0, 0, 1'b1, 1'b0, 1'b0);                       // hard timeout
        play_game(3, 1, 1, 1'b0, 1'b0, 1'b0);                       // easy timeout after toggling
        play_game(0, 0, 0, 1'b0, 1'b1, 1'b0);                       // held button across ESPERA entry
        play_game(0, 0, 0, 1'b0, 1'b0, 1'b1);                       // reset during MOSTRA
        play_game(0, 0, 0, 1'b1, 1'b0, 1'b0);                       // restart after reset
        for (int g = 0; g < 6; g++) begin
            int k, r;
            k = $urandom_range(0, 3);
            r = $urandom_range(0, MR - 1);
            play_game(k, r, $urandom_range(0, r), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        tick(2);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/geogenius_n.md
GEOGENIUS_N -- requirements
Module: geogenius_n

Interface
REQ-001 Parameter NUM_BOTOES, default 8, number of button/LED channels, range 2..16.
REQ-002 Parameter MAX_RODADAS, default 16, sequence depth (rounds to win), range 1..32.
REQ-003 Parameter T_LED, default 1000, cycles a LED stays lit and cycles it stays dark between sequence elements.
REQ-004 Parameters T_TIMEOUT_FACIL, default 5000, and T_TIMEOUT_DIFICIL, default 2500, per-jogada timeout in cycles.
REQ-005 Parameter T_TICK, default 1000, clock cycles per tempo_de_jogo increment.
REQ-006 Parameter SEMENTE, default 16'hACE1, nonzero LFSR seed.
REQ-007 Ports: clock  input  1  system clock, rising edge.
REQ-008 Ports: reset  input  1  asynchronous, active-low reset.
REQ-009 Ports: jogar  input  1  start / restart request, level sampled each cycle.
REQ-010 Ports: dificuldade  input  1  0 = facil, 1 = dificil.
REQ-011 Ports: botoes  input  NUM_BOTOES  player buttons, active-high, synchronous to clock.
REQ-012 Ports: leds  output  NUM_BOTOES  one-hot sequence display.
REQ-013 Ports: pronto, acertou, errou, timeout  output  1 each  end-of-game flags.
REQ-014 Ports: score  output  $clog2(MAX_RODADAS+1)  completed rounds.
REQ-015 Ports: tempo_de_jogo  output  16  elapsed play ticks, binary.
REQ-016 Ports: db_estado  output  4  current state encoding.

Function
REQ-017 States and db_estado codes: INICIAL 0, PREPARA 1, SORTEIA 2, MOSTRA 3, APAGA 4, ESPERA 5, COMPARA 6, PROX_JOGADA 7, PROX_RODADA 8, FIM_ACERTO A, FIM_ERRO E, FIM_TIMEOUT F.
REQ-018 INICIAL/FIM_*: jogar=1 -> PREPARA; jogar ignored in all other states.
REQ-019 PREPARA (1 cycle): clears rodada, jogada index, score, tempo_de_jogo, flags; latches dificuldade; -> SORTEIA.
REQ-020 SORTEIA (1 cycle): stores index = LFSR[4:0] mod NUM_BOTOES in memoria[rodada], one 5-bit entry per round; clears jogada index; -> MOSTRA.
REQ-021 LFSR: 16-bit, taps 16,14,13,11, advances every cycle from reset, never zero.
REQ-022 MOSTRA: leds = one-hot(memoria[jogada index]) for T_LED cycles, then APAGA: leds = 0 for T_LED cycles; if jogada index < rodada, increment and -> MOSTRA, else clear jogada index and -> ESPERA.
REQ-023 ESPERA: fez_jogada = botoes transitions from all-zero to nonzero (registered previous value); on fez_jogada -> COMPARA, registering botoes.
REQ-024 ESPERA: timeout counter counts cycles; reaching latched T_TIMEOUT_FACIL/DIFICIL minus 1 without fez_jogada -> FIM_TIMEOUT; counter clears on every entry to ESPERA.
REQ-025 COMPARA: registered value not one-hot, or its index differs from memoria[jogada index] -> FIM_ERRO; else -> PROX_JOGADA.
REQ-026 PROX_JOGADA: jogada index < rodada -> increment, wait for all buttons released, -> ESPERA; else -> PROX_RODADA.
REQ-027 PROX_RODADA: score increments; rodada = MAX_RODADAS-1 -> FIM_ACERTO; else rodada increments, -> SORTEIA.
REQ-028 Flags: FIM_ACERTO pronto=acertou=1; FIM_ERRO pronto=errou=1; FIM_TIMEOUT pronto=timeout=1; all three held until PREPARA; exactly one result flag set at a time.
REQ-029 tempo_de_jogo increments once per T_TICK cycles spent in ESPERA, saturates at 16'hFFFF, holds in FIM_*.
REQ-030 leds = 0 in every state except MOSTRA.
REQ-031 Button change while in MOSTRA/APAGA is ignored; held button on entry to ESPERA produces no fez_jogada until released.

Reset
REQ-032 reset=0 asynchronously forces INICIAL, leds=0, all flags 0, score=0, tempo_de_jogo=0, counters 0, LFSR=SEMENTE, from any state including mid-sequence.
REQ-033 Memory contents need not be cleared by reset; PREPARA/SORTEIA overwrite before use.

Structure
REQ-034 Shared package geogenius_pkg holds the state enum with the REQ-017 encodings and the LFSR tap constant.
REQ-035 One sub-module geogenius_lfsr (16-bit free-running LFSR, seed parameter); everything else inline.

Verification
REQ-036 Bench parameters: NUM_BOTOES=4, MAX_RODADAS=3, T_LED=4, T_TIMEOUT_FACIL=20, T_TIMEOUT_DIFICIL=10, T_TICK=2.
REQ-037 Win: pulse jogar, echo each shown LED after full display -> acertou=1, pronto=1, score=3, db_estado=A.
REQ-038 Wrong button in round 2 -> errou=1, score=1, db_estado=E, leds=0.
REQ-039 dificuldade=1 at PREPARA, no press -> timeout=1 exactly 10 cycles after ESPERA entry; toggling dificuldade mid-game has no effect.
REQ-040 Two buttons pressed in the same cycle -> FIM_ERRO.
REQ-041 reset=0 during MOSTRA -> outputs cleared asynchronously, db_estado=0; jogar after release restarts with score=0.
REQ-042 tempo_de_jogo: 8 cycles total in ESPERA with T_TICK=2 -> tempo_de_jogo=4, held after FIM_*.
